// File: rtl/bus_io_unit.sv
// Memory/IO slave on the 4-bit CPU bus: external ROM window, 16x4 scratch RAM, GPIO, timer, UART TX.
// UART is built only when BUS_IO_UART_EN is defined; otherwise uart_tx idles high and 0xFF6-0xFF8 read 0.
module bus_io_unit #(
  parameter int unsigned TIMER_DIV    = 16,
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] bus_addr,
  input  logic        bus_data_rw,
  input  logic [3:0]  bus_data_out,
  output logic [3:0]  bus_data_in,
  output logic [11:0] ext_addr,
  input  logic [3:0]  ext_data,
  input  logic [3:0]  gpio_in,
  output logic [3:0]  gpio_out,
  output logic        uart_tx
);

  localparam int unsigned PW = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TIMER_DIV - 1);

  if (TIMER_DIV < 1 || CLKS_PER_BIT < 2) begin : g_param_check
    $error("bus_io_unit: TIMER_DIV must be >= 1 and CLKS_PER_BIT >= 2");
  end

  logic        w_pend_q;
  logic [11:0] w_addr_q;
  logic [3:0]  w_data_q;
  logic        commit;
  logic [3:0]  ram_q [16];
  logic [3:0]  gpio_out_q, gs1_q, gs2_q;
  logic        ten_q, tclr;
  logic [11:0] tmr_q, tmr_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [7:0]  snap_q;

  assign ext_addr = bus_addr;
  assign gpio_out = gpio_out_q;

  // A store is committed once the CPU leaves it (rw drops or address moves), so only the final data lands.
  assign commit = w_pend_q && (!bus_data_rw || (bus_addr != w_addr_q));
  assign tclr   = commit && (w_addr_q == 12'hFF5) && w_data_q[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      w_pend_q   <= 1'b0;
      w_addr_q   <= '0;
      w_data_q   <= '0;
      gpio_out_q <= '0;
      gs1_q      <= '0;
      gs2_q      <= '0;
      ten_q      <= 1'b0;
      tmr_q      <= '0;
      presc_q    <= '0;
      snap_q     <= '0;
      for (int unsigned i = 0; i < 16; i++) ram_q[i] <= '0;
    end else begin
      w_pend_q <= bus_data_rw;
      w_addr_q <= bus_addr;
      w_data_q <= bus_data_out;
      gs1_q    <= gpio_in;
      gs2_q    <= gs1_q;
      tmr_q    <= tmr_d;
      presc_q  <= presc_d;
      if (bus_addr == 12'hFF2 && !bus_data_rw) snap_q <= tmr_q[11:4];
      if (commit && w_addr_q[11:4] == 8'hF0) ram_q[w_addr_q[3:0]] <= w_data_q;
      if (commit && w_addr_q == 12'hFF0) gpio_out_q <= w_data_q;
      if (commit && w_addr_q == 12'hFF5) ten_q <= w_data_q[0];
    end
  end

  always_comb begin
    tmr_d   = tmr_q;
    presc_d = presc_q;
    if (tclr) begin
      tmr_d   = '0;
      presc_d = '0;
    end else if (ten_q) begin
      if (presc_q == PRESC_MAX) begin
        presc_d = '0;
        tmr_d   = tmr_q + 12'd1;
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end
  end

`ifdef BUS_IO_UART_EN
  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {U_IDLE, U_START, U_DATA, U_STOP} uart_state_e;

  uart_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic [3:0]  tx_lo_q, tx_hi_q;
  logic        ovr_q, busy, tx_start, tx_hi_wr, cnt_end;

  assign busy     = (state_q != U_IDLE);
  assign tx_hi_wr = commit && (w_addr_q == 12'hFF7);
  assign tx_start = tx_hi_wr && !busy;
  assign cnt_end  = (cnt_q == CNT_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= U_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_lo_q <= '0;
      tx_hi_q <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      if (commit && w_addr_q == 12'hFF6) tx_lo_q <= w_data_q;
      if (tx_hi_wr) tx_hi_q <= w_data_q;
      // Set after clear so a new overrun always survives.
      if (commit && w_addr_q == 12'hFF8) ovr_q <= 1'b0;
      if (tx_hi_wr && busy) ovr_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    uart_tx = 1'b1;
    case (state_q)
      U_IDLE: begin
        if (tx_start) begin
          state_d = U_START;
          cnt_d   = '0;
          shift_d = {w_data_q, tx_lo_q};
        end
      end
      U_START: begin
        uart_tx = 1'b0;
        if (cnt_end) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = U_DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      U_DATA: begin
        uart_tx = shift_q[0];
        if (cnt_end) begin
          cnt_d   = '0;
          shift_d = shift_q >> 1;
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = U_STOP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      U_STOP: begin
        if (cnt_end) begin
          cnt_d   = '0;
          state_d = U_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = U_IDLE;
    endcase
  end
`else
  assign uart_tx = 1'b1;
`endif

  always_comb begin
    bus_data_in = '0;
    if (bus_addr < 12'hF00) begin
      bus_data_in = ext_data;
    end else if (bus_addr[11:4] == 8'hF0) begin
      bus_data_in = ram_q[bus_addr[3:0]];
    end else begin
      case (bus_addr)
        12'hFF0: bus_data_in = gpio_out_q;
        12'hFF1: bus_data_in = gs2_q;
        12'hFF2: bus_data_in = tmr_q[3:0];
        12'hFF3: bus_data_in = snap_q[3:0];
        12'hFF4: bus_data_in = snap_q[7:4];
        12'hFF5: bus_data_in = {3'b000, ten_q};
`ifdef BUS_IO_UART_EN
        12'hFF6: bus_data_in = tx_lo_q;
        12'hFF7: bus_data_in = tx_hi_q;
        12'hFF8: bus_data_in = {2'b00, ovr_q, busy};
`endif
        default: bus_data_in = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_io_unit.sv
// Directed self-checking bench for bus_io_unit (TIMER_DIV=2, CLKS_PER_BIT=4).
module tb_bus_io_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] bus_addr;
  logic        bus_data_rw;
  logic [3:0]  bus_data_out;
  logic [3:0]  bus_data_in;
  logic [11:0] ext_addr;
  logic [3:0]  ext_data;
  logic [3:0]  gpio_in;
  logic [3:0]  gpio_out;
  logic        uart_tx;

  int checks = 0;
  int failures = 0;

  bus_io_unit #(.TIMER_DIV(2), .CLKS_PER_BIT(4)) dut (
    .clk(clk), .rst(rst), .bus_addr(bus_addr), .bus_data_rw(bus_data_rw),
    .bus_data_out(bus_data_out), .bus_data_in(bus_data_in), .ext_addr(ext_addr),
    .ext_data(ext_data), .gpio_in(gpio_in), .gpio_out(gpio_out), .uart_tx(uart_tx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [11:0] got, input logic [11:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [11:0] a, input logic [3:0] d);
    bus_addr = a; bus_data_out = d; bus_data_rw = 1'b1;
    tick();
    bus_data_rw = 1'b0; bus_addr = 12'h000;
    tick();
  endtask

  task automatic rd(input string tag, input logic [11:0] a, input logic [3:0] exp);
    bus_addr = a; bus_data_rw = 1'b0;
    #1;
    chk(tag, {8'h00, bus_data_in}, {8'h00, exp});
  endtask

`ifdef BUS_IO_UART_EN
  logic [9:0] frame;
`endif

  initial begin
    rst = 1'b1; bus_addr = '0; bus_data_rw = 1'b0; bus_data_out = '0;
    ext_data = '0; gpio_in = '0;
    tick(); tick();
    rst = 1'b0;

    chk("rst_gpio_out", {8'h00, gpio_out}, 12'h000);
    chk("rst_uart_tx", {11'h000, uart_tx}, 12'h001);
    rd("rst_timer", 12'hFF2, 4'h0);
    rd("rst_ram5", 12'hF05, 4'h0);

    gpio_in = 4'h6;
    tick();
    rd("gpio_sync1", 12'hFF1, 4'h0);
    tick();
    rd("gpio_sync2", 12'hFF1, 4'h6);

    bus_addr = 12'hFF0; bus_data_out = 4'h3; bus_data_rw = 1'b1;
    tick();
    chk("glitch_mid1", {8'h00, gpio_out}, 12'h000);
    bus_data_out = 4'hA;
    tick();
    chk("glitch_mid2", {8'h00, gpio_out}, 12'h000);
    bus_data_rw = 1'b0; bus_addr = 12'h000;
    #1;
    chk("glitch_pre", {8'h00, gpio_out}, 12'h000);
    tick();
    chk("glitch_commit", {8'h00, gpio_out}, 12'h00A);
    rd("glitch_ram", 12'hF00, 4'h0);
    rd("glitch_timer", 12'hFF2, 4'h0);

    store(12'hF0F, 4'h7);
    rd("ram_f", 12'hF0F, 4'h7);
    rd("ram_0", 12'hF00, 4'h0);

    ext_data = 4'h5;
    rd("ext_read", 12'h123, 4'h5);
    chk("ext_addr1", ext_addr, 12'h123);
    store(12'h123, 4'h9);
    rd("ext_nowr_ram", 12'hF03, 4'h0);
    chk("ext_nowr_gpio", {8'h00, gpio_out}, 12'h00A);
    bus_addr = 12'hFF0; bus_data_out = 4'h7; bus_data_rw = 1'b1;
    #1;
    chk("ext_addr2", ext_addr, 12'hFF0);
    tick();
    bus_data_rw = 1'b0; bus_addr = 12'h456;
    #1;
    chk("ext_addr3", ext_addr, 12'h456);
    tick();
    chk("gpio_w7", {8'h00, gpio_out}, 12'h007);
    rd("ext_read2", 12'h456, 4'h5);

    store(12'hFF9, 4'hF);
    rd("unmapped_ff9", 12'hFF9, 4'h0);
    rd("unmapped_fff", 12'hFFF, 4'h0);

    // Timer runs from the commit edge; 62 more edges bring it to 0x01F.
    store(12'hFF5, 4'h1);
    repeat (62) tick();
    rd("tmr_lo_1f", 12'hFF2, 4'hF);
    tick();
    rd("tmr_snap_pre", 12'hFF3, 4'h1);
    tick();
    rd("tmr_snap_carry", 12'hFF3, 4'h1);
    rd("tmr_lo_32", 12'hFF2, 4'h0);
    tick();
    rd("tmr_mid_32", 12'hFF3, 4'h2);
    rd("tmr_hi_32", 12'hFF4, 4'h0);
    rd("tctl_en", 12'hFF5, 4'h1);
    store(12'hFF5, 4'h3);
    rd("tmr_clr_lo", 12'hFF2, 4'h0);
    tick();
    rd("tmr_clr_mid", 12'hFF3, 4'h0);
    rd("tmr_clr_hi", 12'hFF4, 4'h0);
    rd("tctl_clr_reads0", 12'hFF5, 4'h1);
    store(12'hFF5, 4'h0);

`ifdef BUS_IO_UART_EN
    store(12'hFF6, 4'h5);
    rd("tx_lo", 12'hFF6, 4'h5);
    frame = {1'b1, 8'hA5, 1'b0};
    bus_addr = 12'hFF7; bus_data_out = 4'hA; bus_data_rw = 1'b1;
    tick();
    bus_data_rw = 1'b0; bus_addr = 12'hFF8;
    tick();
    for (int i = 0; i < 40; i++) begin
      if (i == 10) begin
        bus_addr = 12'hFF7; bus_data_out = 4'h3; bus_data_rw = 1'b1;
      end else if (i == 11) begin
        bus_data_rw = 1'b0; bus_addr = 12'hFF8;
      end
      #1;
      chk($sformatf("uart_line_%0d", i), {11'h000, uart_tx}, {11'h000, frame[i/4]});
      if (i != 10)
        chk($sformatf("uart_stat_%0d", i), {8'h00, bus_data_in}, (i >= 12) ? 12'h003 : 12'h001);
      tick();
    end
    chk("uart_idle_line", {11'h000, uart_tx}, 12'h001);
    rd("uart_stat_end", 12'hFF8, 4'h2);
    rd("uart_txhi_upd", 12'hFF7, 4'h3);
    rd("uart_txlo_keep", 12'hFF6, 4'h5);
    store(12'hFF8, 4'h0);
    rd("ovr_cleared", 12'hFF8, 4'h0);

    store(12'hFF7, 4'h1);
    repeat (5) tick();
    rd("busy_before_rst", 12'hFF8, 4'h1);
`else
    store(12'hFF6, 4'h5);
    store(12'hFF7, 4'hA);
    rd("nouart_ff6", 12'hFF6, 4'h0);
    rd("nouart_ff7", 12'hFF7, 4'h0);
    rd("nouart_ff8", 12'hFF8, 4'h0);
    for (int i = 0; i < 8; i++) begin
      chk("nouart_line", {11'h000, uart_tx}, 12'h001);
      tick();
    end
`endif

    bus_addr = 12'hFF0; bus_data_out = 4'hC; bus_data_rw = 1'b1;
    tick();
    rst = 1'b1; bus_data_rw = 1'b0; bus_addr = 12'h000;
    tick();
    rst = 1'b0;
    chk("rst2_uart_tx", {11'h000, uart_tx}, 12'h001);
    chk("rst2_gpio", {8'h00, gpio_out}, 12'h000);
    rd("rst2_stat", 12'hFF8, 4'h0);
    tick();
    chk("rst2_pend_lost", {8'h00, gpio_out}, 12'h000);
    chk("rst2_uart_tx2", {11'h000, uart_tx}, 12'h001);
    rd("rst2_ram", 12'hF0F, 4'h0);
    rd("rst2_tctl", 12'hFF5, 4'h0);
    rd("rst2_txlo", 12'hFF6, 4'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
